trax_board_engine: RTL and testbench
====================================

Name: trax_board_engine

Overview:
- Parametrised board store and move applier for the Trax player core.
- Accepts one move at a time over a valid/ready handshake; validates it, grows the board, and shifts the board down and/or right when a tile is placed above row 0 or left of column 0.
- Infers the new tile's colour bit from its neighbours and writes the tile.
- Provides a registered read port for the move generator and auto-complete logic.
- Sits between the transceiver and the move search/auto-complete blocks.

Parameters:
- MAX_ROW, 8, physical board rows (>=2).
- MAX_COL, 8, physical board columns (>=2).
- CW, 10, coordinate field width inside a move word.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- move_in  in  2*CW+2  move word: [2CW+1:2CW] tile (01 plus, 10 slash, 11 bslash); [2CW-1:CW] col; [CW-1:0] row.
- move_valid  in  1  move_in is presented.
- move_ready  out  1  high only in IDLE.
- clear  in  1  sampled in IDLE only; empties the board.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a move completes, accepted or rejected.
- err  out  2  code valid with done: 0 ok, 1 occupied, 2 out of range / no room, 3 isolated; held until the next done.
- n_rows  out  CW  used rows.
- n_cols  out  CW  used columns.
- rd_row  in  CW  read row address.
- rd_col  in  CW  read column address.
- rd_cell  out  3  registered cell: [2:1] tile, [0] colour (0 white, 1 black).

Behaviour:
- Reset (reset low, asynchronous), asserted mid-operation included:
  - All cells 000; n_rows = n_cols = 0; state IDLE.
  - done = 0, err = 0, busy = 0, move_ready = 1, rd_cell = 000.
- Coordinate encoding:
  - row all-ones means "new row above"; col all-ones means "new column left".
  - row == n_rows means "new row below"; col == n_cols means "new column right".
- States: IDLE, CLEAR, CHECK, SHIFT_DN, SHIFT_RT, PLACE.
- IDLE:
  - If move_valid, latch move_in and go to CHECK.
  - Otherwise, if clear, go to CLEAR.
  - move_valid has priority over clear in the same cycle.
- CLEAR:
  - Zeroes one physical row per cycle, MAX_ROW cycles in total.
  - Then n_rows = n_cols = 0, return to IDLE. No done pulse.
- CHECK (1 cycle), in this priority order:
  - Range/room: if the board is empty, row and col must both be 0. Otherwise an above/below move requires n_rows < MAX_ROW, a left/right move requires n_cols < MAX_COL, and any other value out of range gives err 2.
  - Occupied: an in-range target cell that is non-empty gives err 1.
  - Isolated: all four neighbours empty on a non-empty board gives err 3.
  - On error: done pulse with err in the next cycle, return to IDLE, board and n_rows/n_cols unchanged.
  - On success: go to SHIFT_DN if row is all-ones; else SHIFT_RT if col is all-ones; else PLACE.
- SHIFT_DN:
  - One row per cycle, r = n_rows-1 down to 0: row r+1 <= row r.
  - On the final cycle row 0 is cleared; n_rows increments; target row becomes 0.
  - n_rows cycles total. Then SHIFT_RT if col is all-ones, else PLACE.
- SHIFT_RT:
  - Same scheme per column: col c+1 <= col c, column 0 cleared on the final cycle.
  - n_cols increments; n_cols cycles total.
- PLACE (1 cycle):
  - Write the tile; grow n_rows/n_cols for a below/right move; first move on an empty board sets n_rows = n_cols = 1.
  - done pulses the next cycle with err 0, together with the updated n_rows/n_cols.
- Colour inference: evaluate the non-empty neighbours in order up, down, left, right; the last one evaluated wins.
  - Up: same colour if up tile is plus, else inverted.
  - Down: same colour if the new tile is plus, else inverted.
  - Left: same colour if (left != bslash and new != slash) or (left == bslash and new == slash), else inverted.
  - Right: same colour if (right != slash and new != bslash) or (right == slash and new == bslash), else inverted.
  - First move: colour 0.
- Latency, counted from the handshake edge:
  - Accepted move: done is high exactly 2+S cycles later, where S is the total shift cycles.
  - Rejected move: done is high 1 cycle later.
- Read port:
  - rd_cell updates 1 cycle after the address and returns 000 for addresses outside MAX_ROW x MAX_COL.
  - Data read while busy may reflect a partial shift; consumers read only when busy = 0.

Test Plan:
1. Reset, then move {01,0,0} -> done at +2, err 0, n_rows = n_cols = 1, cell(0,0) = 010.
2. Then {10, col 0, row 1} -> done at +2, n_rows = 2, cell(1,0) = 100 (up is plus, same colour 0).
3. Then {11, col 0, row 3FF} -> done at +4 (S = 2), n_rows = 3, cell(1,0) = 010, cell(2,0) = 100, cell(0,0) = 111 (down rule, inverted).
4. Move {01,0,0} on the occupied cell -> done at +1, err 1, board and n_rows unchanged. Then move {01,5,0} with n_cols = 1 -> err 2.
5. MAX_ROW = 4: fill to n_rows = 4, then move with row 3FF -> err 2. Then assert clear -> busy for 4 cycles, n_rows = 0, all cells read 000.
6. Drive reset low during SHIFT_DN -> all outputs at reset values immediately. After release, move_ready = 1 and the board is empty.

Source files
------------

// File: rtl/trax_board_engine.sv
// Trax board store and move applier: validates a move, grows/shifts the board,
// infers the new tile's colour from its neighbours and exposes a registered read port.
module trax_board_engine #(
    parameter int MAX_ROW = 8,
    parameter int MAX_COL = 8,
    parameter int CW      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2*CW+1:0] move_in,
    input  logic            move_valid,
    output logic            move_ready,
    input  logic            clear,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err,
    output logic [CW-1:0]   n_rows,
    output logic [CW-1:0]   n_cols,
    input  logic [CW-1:0]   rd_row,
    input  logic [CW-1:0]   rd_col,
    output logic [2:0]      rd_cell
);

    // Handshake: a move transfers on a rising clk edge where move_valid && move_ready.
    localparam logic [1:0] T_PLUS   = 2'b01;
    localparam logic [1:0] T_SLASH  = 2'b10;
    localparam logic [1:0] T_BSLASH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_CHECK, S_SHIFT_DN, S_SHIFT_RT, S_PLACE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]      board [MAX_ROW][MAX_COL];
    logic [2*CW+1:0] mv;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   tr_q;
    logic [CW-1:0]   tc_q;

    logic [1:0]    m_tile;
    logic [CW-1:0] m_col;
    logic [CW-1:0] m_row;
    logic          row_above;
    logic          col_left;

    assign m_tile    = mv[2*CW+1:2*CW];
    assign m_col     = mv[2*CW-1:CW];
    assign m_row     = mv[CW-1:0];
    assign row_above = &m_row;
    assign col_left  = &m_col;

    assign busy       = (state != S_IDLE);
    assign move_ready = (state == S_IDLE);

    // Cells outside the physical array (including negative coordinates) read as empty.
    function automatic logic [2:0] cell_at(input int r, input int c);
        logic [2:0] v;
        v = 3'b000;
        for (int i = 0; i < MAX_ROW; i++)
            for (int j = 0; j < MAX_COL; j++)
                if (r == i && c == j) v = board[i][j];
        return v;
    endfunction

    // Move validation, evaluated against the latched move in CHECK.
    int         ri, ci;
    logic       row_ok, col_ok, range_ok, occupied, isolated;
    logic [1:0] chk_err;

    always_comb begin
        ri       = row_above ? -1 : int'(m_row);
        ci       = col_left  ? -1 : int'(m_col);
        row_ok   = 1'b0;
        col_ok   = 1'b0;
        range_ok = 1'b0;
        if (n_rows == '0) begin
            range_ok = (m_row == '0) && (m_col == '0);
        end else begin
            if (row_above || m_row == n_rows) row_ok = n_rows < CW'(MAX_ROW);
            else                              row_ok = m_row < n_rows;
            if (col_left || m_col == n_cols)  col_ok = n_cols < CW'(MAX_COL);
            else                              col_ok = m_col < n_cols;
            range_ok = row_ok && col_ok;
        end
        occupied = cell_at(ri, ci) != 3'b000;
        isolated = (n_rows != '0) &&
                   cell_at(ri - 1, ci) == 3'b000 && cell_at(ri + 1, ci) == 3'b000 &&
                   cell_at(ri, ci - 1) == 3'b000 && cell_at(ri, ci + 1) == 3'b000;
        if (!range_ok)     chk_err = 2'd2;
        else if (occupied) chk_err = 2'd1;
        else if (isolated) chk_err = 2'd3;
        else               chk_err = 2'd0;
    end

    // Colour inference at the post-shift target; later neighbours override earlier ones.
    logic [2:0] nb_up, nb_dn, nb_lt, nb_rt;
    logic       colour;

    always_comb begin
        nb_up  = cell_at(int'(tr_q) - 1, int'(tc_q));
        nb_dn  = cell_at(int'(tr_q) + 1, int'(tc_q));
        nb_lt  = cell_at(int'(tr_q), int'(tc_q) - 1);
        nb_rt  = cell_at(int'(tr_q), int'(tc_q) + 1);
        colour = 1'b0;
        if (nb_up != 3'b000)
            colour = (nb_up[2:1] == T_PLUS) ? nb_up[0] : ~nb_up[0];
        if (nb_dn != 3'b000)
            colour = (m_tile == T_PLUS) ? nb_dn[0] : ~nb_dn[0];
        if (nb_lt != 3'b000)
            colour = ((nb_lt[2:1] != T_BSLASH && m_tile != T_SLASH) ||
                      (nb_lt[2:1] == T_BSLASH && m_tile == T_SLASH)) ? nb_lt[0] : ~nb_lt[0];
        if (nb_rt != 3'b000)
            colour = ((nb_rt[2:1] != T_SLASH && m_tile != T_BSLASH) ||
                      (nb_rt[2:1] == T_SLASH && m_tile == T_BSLASH)) ? nb_rt[0] : ~nb_rt[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (move_valid) state_nxt = S_CHECK;
                else if (clear) state_nxt = S_CLEAR;
            end
            S_CLEAR:    if (cnt == CW'(MAX_ROW - 1)) state_nxt = S_IDLE;
            S_CHECK: begin
                if (chk_err != 2'd0) state_nxt = S_IDLE;
                else if (row_above)  state_nxt = S_SHIFT_DN;
                else if (col_left)   state_nxt = S_SHIFT_RT;
                else                 state_nxt = S_PLACE;
            end
            S_SHIFT_DN: if (cnt == '0) state_nxt = col_left ? S_SHIFT_RT : S_PLACE;
            S_SHIFT_RT: if (cnt == '0) state_nxt = S_PLACE;
            S_PLACE:    state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_ROW; i++)
                for (int j = 0; j < MAX_COL; j++)
                    board[i][j] <= 3'b000;
            mv      <= '0;
            cnt     <= '0;
            tr_q    <= '0;
            tc_q    <= '0;
            n_rows  <= '0;
            n_cols  <= '0;
            done    <= 1'b0;
            err     <= 2'd0;
            rd_cell <= 3'b000;
        end else begin
            done    <= 1'b0;
            rd_cell <= cell_at(int'(rd_row), int'(rd_col));
            case (state)
                S_IDLE: begin
                    if (move_valid) mv  <= move_in;
                    else if (clear) cnt <= '0;
                end
                S_CLEAR: begin
                    for (int i = 0; i < MAX_ROW; i++)
                        if (cnt == CW'(i))
                            for (int j = 0; j < MAX_COL; j++) board[i][j] <= 3'b000;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MAX_ROW - 1)) begin
                        n_rows <= '0;
                        n_cols <= '0;
                    end
                end
                S_CHECK: begin
                    if (chk_err != 2'd0) begin
                        done <= 1'b1;
                        err  <= chk_err;
                    end else begin
                        tr_q <= row_above ? '0 : m_row;
                        tc_q <= col_left  ? '0 : m_col;
                        cnt  <= row_above ? n_rows - CW'(1) : n_cols - CW'(1);
                    end
                end
                S_SHIFT_DN: begin
                    for (int i = 1; i < MAX_ROW; i++)
                        if (cnt == CW'(i - 1))
                            for (int j = 0; j < MAX_COL; j++) board[i][j] <= board[i-1][j];
                    if (cnt == '0) begin
                        for (int j = 0; j < MAX_COL; j++) board[0][j] <= 3'b000;
                        n_rows <= n_rows + CW'(1);
                        cnt    <= n_cols - CW'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SHIFT_RT: begin
                    for (int j = 1; j < MAX_COL; j++)
                        if (cnt == CW'(j - 1))
                            for (int i = 0; i < MAX_ROW; i++) board[i][j] <= board[i][j-1];
                    if (cnt == '0) begin
                        for (int i = 0; i < MAX_ROW; i++) board[i][0] <= 3'b000;
                        n_cols <= n_cols + CW'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PLACE: begin
                    for (int i = 0; i < MAX_ROW; i++)
                        for (int j = 0; j < MAX_COL; j++)
                            if (tr_q == CW'(i) && tc_q == CW'(j)) board[i][j] <= {m_tile, colour};
                    // A target on the first unused row/column grows the board; covers the first move too.
                    if (tr_q == n_rows) n_rows <= n_rows + CW'(1);
                    if (tc_q == n_cols) n_cols <= n_cols + CW'(1);
                    done <= 1'b1;
                    err  <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trax_board_engine.sv
// Directed bench for trax_board_engine: moves are pushed with expected
// done latency/err/size into a queue that a done-triggered monitor drains.
module tb_trax_board_engine;

    localparam int CW = 10;
    localparam int MR = 4;
    localparam int MC = 4;
    localparam int W  = 32 + 2 + 2 * CW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [2*CW+1:0] move_in = '0;
    logic            move_valid = 1'b0;
    logic            clear = 1'b0;
    logic [CW-1:0]   rd_row = '0;
    logic [CW-1:0]   rd_col = '0;
    logic            move_ready, busy, done;
    logic [1:0]      err;
    logic [CW-1:0]   n_rows, n_cols;
    logic [2:0]      rd_cell;

    logic [W-1:0] exp_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    trax_board_engine #(.MAX_ROW(MR), .MAX_COL(MC), .CW(CW)) dut (
        .clk(clk), .reset(reset), .move_in(move_in), .move_valid(move_valid),
        .move_ready(move_ready), .clear(clear), .busy(busy), .done(done), .err(err),
        .n_rows(n_rows), .n_cols(n_cols), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e[W-1:2+2*CW]);
                chk("err", {30'd0, err}, {30'd0, e[2*CW+1:2*CW]});
                chk("n_rows", {22'd0, n_rows}, {22'd0, e[2*CW-1:CW]});
                chk("n_cols", {22'd0, n_cols}, {22'd0, e[CW-1:0]});
            end
        end
    end

    task automatic wait_idle();
        int k;
        @(negedge clk);
        k = 0;
        while (!move_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!move_ready) begin
            n_checks++;
            $display("FAIL idle_timeout: got move_ready=0, expected 1 within 100 cycles");
        end
    endtask

    task automatic do_move(input logic [1:0] tile, input logic [CW-1:0] col, input logic [CW-1:0] row,
                           input logic [1:0] e_err, input logic [CW-1:0] e_nr,
                           input logic [CW-1:0] e_nc, input int lat);
        wait_idle();
        move_in    = {tile, col, row};
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        exp_q.push_back({32'(cyc + lat), e_err, e_nr, e_nc});
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL done_timeout: got no done, expected done at cycle %0d", exp_q[0][W-1:2+2*CW]);
            exp_q.delete();
        end
    endtask

    task automatic read_cell(input int r, input int c, input logic [2:0] exp, input string name);
        @(negedge clk);
        rd_row = CW'(r);
        rd_col = CW'(c);
        @(posedge clk);
        @(negedge clk);
        chk(name, {29'd0, rd_cell}, {29'd0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_move_ready"}, {31'd0, move_ready}, 32'd1);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_err"},        {30'd0, err},        32'd0);
        chk({tag, "_n_rows"},     {22'd0, n_rows},     32'd0);
        chk({tag, "_n_cols"},     {22'd0, n_cols},     32'd0);
        chk({tag, "_rd_cell"},    {29'd0, rd_cell},    32'd0);
    endtask

    initial begin
        int bcnt;
        logic [2:0] acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Build a column: plus, slash below, bslash inserted above.
        do_move(2'b01, 10'd0, 10'd0, 2'd0, 10'd1, 10'd1, 2);
        read_cell(0, 0, 3'b010, "cell00_first");
        do_move(2'b10, 10'd0, 10'd1, 2'd0, 10'd2, 10'd1, 2);
        read_cell(1, 0, 3'b100, "cell10_up_rule");
        do_move(2'b11, 10'd0, 10'h3FF, 2'd0, 10'd3, 10'd1, 4);
        read_cell(0, 0, 3'b111, "cell00_down_rule");
        read_cell(1, 0, 3'b010, "cell10_shifted");
        read_cell(2, 0, 3'b100, "cell20_shifted");

        // Rejections: occupied, out of range, isolated.
        do_move(2'b01, 10'd0, 10'd0, 2'd1, 10'd3, 10'd1, 1);
        read_cell(0, 0, 3'b111, "cell00_unchanged");
        do_move(2'b01, 10'd5, 10'd0, 2'd2, 10'd3, 10'd1, 1);
        do_move(2'b01, 10'd1, 10'd3, 2'd3, 10'd3, 10'd1, 1);

        // Right growth (left rule) and a left insertion with column shift (right rule).
        do_move(2'b10, 10'd1, 10'd0, 2'd0, 10'd3, 10'd2, 2);
        read_cell(0, 1, 3'b101, "cell01_left_rule");
        do_move(2'b01, 10'h3FF, 10'd0, 2'd0, 10'd3, 10'd3, 4);
        read_cell(0, 0, 3'b011, "cell00_right_rule");
        read_cell(0, 1, 3'b111, "cell01_shifted");
        read_cell(0, 2, 3'b101, "cell02_shifted");
        read_cell(2, 1, 3'b100, "cell21_shifted");
        read_cell(2, 0, 3'b000, "cell20_cleared");

        // Fill to MAX_ROW, then no room above or below.
        do_move(2'b01, 10'd1, 10'd3, 2'd0, 10'd4, 10'd3, 2);
        read_cell(3, 1, 3'b011, "cell31_below");
        do_move(2'b01, 10'd1, 10'h3FF, 2'd2, 10'd4, 10'd3, 1);
        do_move(2'b01, 10'd1, 10'd4, 2'd2, 10'd4, 10'd3, 1);
        read_cell(5, 0, 3'b000, "read_row_oob");
        read_cell(0, 7, 3'b000, "read_col_oob");

        // Clear: busy for MAX_ROW cycles, board and size emptied.
        wait_idle();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
        chk("clear_busy_cycles", bcnt, 32'd4);
        chk("clear_n_rows", {22'd0, n_rows}, 32'd0);
        chk("clear_n_cols", {22'd0, n_cols}, 32'd0);
        acc = 3'b000;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) begin
                @(negedge clk);
                rd_row = CW'(r);
                rd_col = CW'(c);
                @(posedge clk);
                @(negedge clk);
                acc = acc | rd_cell;
            end
        chk("clear_cells", {29'd0, acc}, 32'd0);

        // Empty board accepts only (0,0).
        do_move(2'b01, 10'd0, 10'd1, 2'd2, 10'd0, 10'd0, 1);
        do_move(2'b01, 10'd0, 10'd0, 2'd0, 10'd1, 10'd1, 2);
        do_move(2'b10, 10'd0, 10'd1, 2'd0, 10'd2, 10'd1, 2);

        // Reset asserted in the middle of a down shift.
        wait_idle();
        move_in    = {2'b11, 10'd0, 10'h3FF};
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("in_shift_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        read_cell(0, 0, 3'b000, "post_reset_cell00");
        read_cell(1, 0, 3'b000, "post_reset_cell10");
        read_cell(2, 0, 3'b000, "post_reset_cell20");
        chk("post_reset_ready", {31'd0, move_ready}, 32'd1);
        do_move(2'b01, 10'd0, 10'd0, 2'd0, 10'd1, 10'd1, 2);
        read_cell(0, 0, 3'b010, "post_reset_first");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
